mc_main_control: RTL and testbench
==================================

Name: mc_main_control

Overview:
- Multicycle successor to the single-cycle main decoder.
- A Moore FSM that sequences each MIPS instruction through fetch, decode, execute, memory and writeback states, and generates per-cycle datapath enables.
- Sits between the instruction register and the shared multicycle datapath: PC, IR, register file, ALU and a unified memory with a ready handshake.
- Adds memory wait-states, a bus timeout, and an illegal-instruction trap.

Parameters:
- ALUOP_W, 4, width of ALUOp; codes are taken from the shared package, upper bits zero-padded if ALUOP_W > 4.
- TIMEOUT, 16, maximum cycles to wait for mem_ready before trapping (legal range 1..255).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- run  in  1  leave IDLE and begin fetching
- Opcode  in  6  IR[31:26], valid from DECODE onward
- func  in  6  IR[5:0]
- mem_ready  in  1  memory completed the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load gated by the branch condition
- IorD  out  1  memory address select (0 = PC, 1 = ALUOut)
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load the instruction register
- RegDst  out  1  destination register select (1 = rd)
- RegWrite  out  1  register file write
- MemtoReg  out  1  writeback source (1 = MDR)
- ALUSrcA  out  1  ALU A select (0 = PC, 1 = rs)
- ALUSrcB  out  2  ALU B select (00 rt, 01 const 4, 10 sign-extended immediate, 11 immediate<<2)
- PCSource  out  2  PC source (00 ALU, 01 ALUOut, 10 jump target, 11 rs for jr)
- ALUOp  out  ALUOP_W  ALU operation code
- Jal  out  1  write PC+4 to $31
- Bneq  out  1  invert the branch condition
- illegal  out  1  sticky: undefined opcode/func
- bus_err  out  1  sticky: memory timeout
- state  out  4  current state, for debug

Behaviour:
- Reset: when rst_n is sampled low at a clk edge, state becomes IDLE, the wait counter clears, and illegal and bus_err clear. This applies mid-instruction as well; there is no partial completion.
- Outputs are decoded purely from state plus the latched Opcode/func. Every output is 0 in IDLE and TRAP, except the sticky flags.
- IDLE -> FETCH when run = 1.
- FETCH:
  - Asserts MemRead, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = add.
  - Holds until mem_ready. On the mem_ready cycle it also asserts IRWrite and PCWrite (PC <= PC + 4), then goes to DECODE.
- DECODE:
  - Asserts ALUSrcA = 0, ALUSrcB = 11, ALUOp = add (branch target into ALUOut).
  - Next state by Opcode:
    - R-type -> EXEC_R, or JR when func = 001000.
    - addi/addiu/andi/ori/slti/sltiu/lui/ll -> EXEC_I.
    - lw/sw -> MEM_ADDR.
    - beq/bne -> BRANCH.
    - j/jal -> JUMP.
    - Anything else, or an R-type with an undefined func -> TRAP with illegal set.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp from func per the package table. Next state WB_R.
- WB_R: RegDst = 1, RegWrite = 1. Next state FETCH.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp per opcode. Next state WB_I.
- WB_I: RegDst = 0, RegWrite = 1. Next state FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = add. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead, IorD = 1. Waits for mem_ready, then goes to WB_MEM.
- WB_MEM: RegWrite, MemtoReg = 1, RegDst = 0. Next state FETCH.
- MEM_WR: MemWrite, IorD = 1. Waits for mem_ready, then goes to FETCH.
- BRANCH:
  - ALUSrcA = 1, ALUSrcB = 00, ALUOp = sub, PCWriteCond = 1, PCSource = 01.
  - Bneq = 1 for bne, which also uses ALUSrcB = 00 (this corrects the old immediate source).
  - Next state FETCH.
- JUMP: PCWrite = 1, PCSource = 10; Jal = 1 and RegWrite = 1 for jal. Next state FETCH.
- JR: PCWrite = 1, PCSource = 11. Next state FETCH.
- Wait states and timeout:
  - In FETCH/MEM_RD/MEM_WR, the wait counter increments each cycle that mem_ready = 0, and clears on state exit.
  - If the counter reaches TIMEOUT with mem_ready still 0, set bus_err and go to TRAP. If mem_ready arrives on that same cycle, mem_ready wins: normal transition, no error.
- TRAP: absorbing; only reset leaves it. The sticky flags hold.
- Opcode/func are latched into internal registers on the DECODE cycle, so IR changes after DECODE do not affect the instruction in flight.
- run is sampled only in IDLE; deasserting it mid-instruction has no effect.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum (4-bit);
  - opcode and func localparams;
  - ALUOp codes: add 0001, addu 0010, and 0011, or 0100, nor 0101, sltu 0110, slt 0111, sll 1000, srl 1001, sub 1010, subu 1011, sra 1100, lui 1101, pass 0000;
  - the ALUSrcB and PCSource encodings.
- One sub-module, mc_aluop_decode: combinational opcode/func -> ALUOp and legal flag, reused by EXEC_R and EXEC_I.

Test Plan:
- Reset mid-MEM_RD with rst_n = 0 for 1 cycle -> next state IDLE, all outputs 0, bus_err = 0; then run = 1 -> FETCH with MemRead = 1.
- add (Opcode 000000, func 100000) with mem_ready immediate -> states FETCH, DECODE, EXEC_R, WB_R, FETCH (4 cycles); ALUOp = 0001 in EXEC_R; RegWrite = 1 only in WB_R.
- lw with mem_ready delayed 3 cycles in MEM_RD -> MEM_RD held 4 cycles with MemRead = 1, IorD = 1; WB_MEM asserts MemtoReg = 1, RegWrite = 1.
- bne (000101) -> BRANCH asserts PCWriteCond = 1, Bneq = 1, ALUOp = 1010, ALUSrcB = 00.
- mem_ready held 0 in FETCH with TIMEOUT = 16 -> bus_err = 1 after 16 wait cycles, state TRAP; a variant that raises mem_ready on cycle 16 completes the fetch normally.
- Opcode 111111, or R-type func 111111 -> TRAP after DECODE with illegal = 1, RegWrite/MemWrite never asserted.

Source files
------------

// File: rtl/mc_main_control_pkg.sv
// mc_ctrl_pkg: shared definitions for the multicycle MIPS main control.
//   state_t        - 4-bit controller state, also exported on the debug port
//   OP_* / FN_*    - IR[31:26] opcode and IR[5:0] func values
//   ALU_*          - 4-bit ALUOp codes understood by the ALU
//   SRCB_* / PCS_* - ALUSrcB and PCSource mux encodings
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_JR       = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LL    = 6'b110000;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_SUBU = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b1101;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

endpackage

// File: rtl/mc_main_control_if.sv
// mc_main_control_if: controller <-> datapath/memory bundle.
//   master (controller): in run, Opcode, func, mem_ready;
//                        out datapath enables, ALUOp, illegal, bus_err, state
//   slave  (datapath/host side): the mirror image
interface mc_main_control_if #(
  parameter int unsigned ALUOP_W = 4
);
  logic               run;
  logic [5:0]         Opcode;
  logic [5:0]         func;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               RegWrite;
  logic               MemtoReg;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSource;
  logic [ALUOP_W-1:0] ALUOp;
  logic               Jal;
  logic               Bneq;
  logic               illegal;
  logic               bus_err;
  logic [3:0]         state;

  modport master (
    input  run, Opcode, func, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
           RegWrite, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, Jal, Bneq,
           illegal, bus_err, state
  );

  modport slave (
    output run, Opcode, func, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
           RegWrite, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, Jal, Bneq,
           illegal, bus_err, state
  );
endinterface

// File: rtl/mc_main_control_aluop_decode.sv
// mc_aluop_decode: combinational opcode/func -> 4-bit ALUOp plus legal flag.
//   opcode, func : instruction fields
//   aluop        : ALU code for R-type (by func) or I-type ALU ops (by opcode);
//                  ALU_PASS for non-ALU instructions
//   legal        : 1 when the opcode (and func, for R-type) is implemented
module mc_aluop_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic [3:0] aluop,
  output logic       legal
);

  always_comb begin
    aluop = ALU_PASS;
    legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  aluop = ALU_ADD;
          FN_ADDU: aluop = ALU_ADDU;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_NOR:  aluop = ALU_NOR;
          FN_SLTU: aluop = ALU_SLTU;
          FN_SLT:  aluop = ALU_SLT;
          FN_SLL:  aluop = ALU_SLL;
          FN_SRL:  aluop = ALU_SRL;
          FN_SUB:  aluop = ALU_SUB;
          FN_SUBU: aluop = ALU_SUBU;
          FN_SRA:  aluop = ALU_SRA;
          FN_JR:   aluop = ALU_PASS;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LL: aluop = ALU_ADD;
      OP_ADDIU:       aluop = ALU_ADDU;
      OP_ANDI:        aluop = ALU_AND;
      OP_ORI:         aluop = ALU_OR;
      OP_SLTI:        aluop = ALU_SLT;
      OP_SLTIU:       aluop = ALU_SLTU;
      OP_LUI:         aluop = ALU_LUI;
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: aluop = ALU_PASS;
      default:        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// mc_main_control: Moore-style multicycle MIPS main control FSM.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mc_main_control_if.master - run/IR fields/mem_ready in,
//                datapath enables, ALUOp, sticky illegal/bus_err, debug state out
// Parameters: ALUOP_W (>= 4, zero-padded ALUOp), TIMEOUT (1..255 cycles of
// mem_ready wait before trapping), CNT_W (2**CNT_W > TIMEOUT).
module mc_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_main_control_if.master bus
);

  state_t             state_q, state_d;
  logic [5:0]         op_q, fn_q;
  logic [CNT_W-1:0]   wait_q, wait_d, cnt_inc;
  logic               ill_q, berr_q;
  logic               set_ill, set_berr;
  logic               wait_state, timeout;
  logic [5:0]         dec_op, dec_fn;
  logic [3:0]         dec_aluop, alu_code;
  logic               dec_legal;

  // One decoder serves both DECODE (live IR, for legality/dispatch) and the
  // execute states (latched IR, for ALUOp).
  assign dec_op = (state_q == S_DECODE) ? bus.Opcode : op_q;
  assign dec_fn = (state_q == S_DECODE) ? bus.func   : fn_q;

  mc_aluop_decode u_aluop_decode (
    .opcode (dec_op),
    .func   (dec_fn),
    .aluop  (dec_aluop),
    .legal  (dec_legal)
  );

  // Timeout fires on the cycle the incremented count would reach TIMEOUT,
  // but only while mem_ready is still low, so a same-cycle ready wins.
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                      (state_q == S_MEM_WR);
  assign cnt_inc    = wait_q + 1'b1;
  assign timeout    = wait_state && !bus.mem_ready &&
                      (cnt_inc == CNT_W'(TIMEOUT));

  always_comb begin
    if (!wait_state || bus.mem_ready || timeout) wait_d = '0;
    else                                         wait_d = cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (set_ill)  ill_q  <= 1'b1;
      if (set_berr) berr_q <= 1'b1;
      if (state_q == S_DECODE) begin
        op_q <= bus.Opcode;
        fn_q <= bus.func;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    set_ill  = 1'b0;
    set_berr = 1'b0;
    case (state_q)
      S_IDLE: if (bus.run) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else if (timeout) begin
          state_d  = S_TRAP;
          set_berr = 1'b1;
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          state_d = S_TRAP;
          set_ill = 1'b1;
        end else begin
          case (dec_op)
            OP_RTYPE: state_d = (dec_fn == FN_JR) ? S_JR : S_EXEC_R;
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU, OP_LUI,
            OP_LL:         state_d = S_EXEC_I;
            OP_LW, OP_SW:  state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J, OP_JAL:  state_d = S_JUMP;
            default: begin
              state_d = S_TRAP;
              set_ill = 1'b1;
            end
          endcase
        end
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     state_d = S_FETCH;
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (bus.mem_ready) state_d = S_WB_MEM;
        else if (timeout) begin
          state_d  = S_TRAP;
          set_berr = 1'b1;
        end
      end
      S_WB_MEM:   state_d = S_FETCH;
      S_MEM_WR: begin
        if (bus.mem_ready) state_d = S_FETCH;
        else if (timeout) begin
          state_d  = S_TRAP;
          set_berr = 1'b1;
        end
      end
      S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = SRCB_RT;
    bus.PCSource    = PCS_ALU;
    bus.Jal         = 1'b0;
    bus.Bneq        = 1'b0;
    alu_code        = ALU_PASS;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        alu_code    = ALU_ADD;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
        end
      end
      S_DECODE: begin
        bus.ALUSrcB = SRCB_IMM_SH;
        alu_code    = ALU_ADD;
      end
      S_EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_RT;
        alu_code    = dec_aluop;
      end
      S_WB_R: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        alu_code    = dec_aluop;
      end
      S_WB_I: bus.RegWrite = 1'b1;
      S_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        alu_code    = ALU_ADD;
      end
      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_WB_MEM: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = SRCB_RT;
        alu_code        = ALU_SUB;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = PCS_ALUOUT;
        bus.Bneq        = (op_q == OP_BNE);
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = PCS_JUMP;
        if (op_q == OP_JAL) begin
          bus.Jal      = 1'b1;
          bus.RegWrite = 1'b1;
        end
      end
      S_JR: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = PCS_RS;
      end
      default: ;
    endcase
  end

  assign bus.ALUOp   = ALUOP_W'(alu_code);
  assign bus.illegal = ill_q;
  assign bus.bus_err = berr_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_mc_main_control.sv
module tb_mc_main_control;
  localparam int unsigned TO = 16;

  localparam logic [3:0] T_IDLE = 4'd0, T_FETCH = 4'd1, T_DECODE = 4'd2,
    T_EXEC_R = 4'd3, T_WB_R = 4'd4, T_EXEC_I = 4'd5, T_WB_I = 4'd6,
    T_MEM_ADDR = 4'd7, T_MEM_RD = 4'd8, T_WB_MEM = 4'd9, T_MEM_WR = 4'd10,
    T_BRANCH = 4'd11, T_JUMP = 4'd12, T_JR = 4'd13, T_TRAP = 4'd14;

  localparam int C_R = 0, C_JR = 1, C_I = 2, C_LW = 3, C_SW = 4, C_BR = 5,
    C_J = 6, C_ILL = 7;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, iord, mrd, mwr, irw, rdst, rw, m2r, srca;
    logic [1:0] srcb, pcsrc;
    logic [3:0] aluop;
    logic jal, bneq, ill, berr;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_main_control_if #(.ALUOP_W(4)) bus ();
  mc_main_control #(.ALUOP_W(4), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  obs_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  bit          m_ill = 1'b0;
  bit          m_berr = 1'b0;

  // ---------------- reference model (instruction-level) ----------------
  function automatic logic [4:0] r_alu(logic [5:0] fn);
    case (fn)
      6'b100000: return 5'h10 | 5'd1;   // add
      6'b100001: return 5'h10 | 5'd2;   // addu
      6'b100100: return 5'h10 | 5'd3;   // and
      6'b100101: return 5'h10 | 5'd4;   // or
      6'b100111: return 5'h10 | 5'd5;   // nor
      6'b101011: return 5'h10 | 5'd6;   // sltu
      6'b101010: return 5'h10 | 5'd7;   // slt
      6'b000000: return 5'h10 | 5'd8;   // sll
      6'b000010: return 5'h10 | 5'd9;   // srl
      6'b100010: return 5'h10 | 5'd10;  // sub
      6'b100011: return 5'h10 | 5'd11;  // subu
      6'b000011: return 5'h10 | 5'd12;  // sra
      default:   return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] i_alu(logic [5:0] op);
    case (op)
      6'b001000: return 5'h10 | 5'd1;   // addi
      6'b001001: return 5'h10 | 5'd2;   // addiu
      6'b001100: return 5'h10 | 5'd3;   // andi
      6'b001101: return 5'h10 | 5'd4;   // ori
      6'b001010: return 5'h10 | 5'd7;   // slti
      6'b001011: return 5'h10 | 5'd6;   // sltiu
      6'b001111: return 5'h10 | 5'd13;  // lui
      6'b110000: return 5'h10 | 5'd1;   // ll
      default:   return 5'd0;
    endcase
  endfunction

  function automatic int cls(logic [5:0] op, logic [5:0] fn);
    logic [4:0] v;
    if (op == 6'b000000) begin
      if (fn == 6'b001000) return C_JR;
      v = r_alu(fn);
      return v[4] ? C_R : C_ILL;
    end
    v = i_alu(op);
    if (v[4]) return C_I;
    case (op)
      6'b100011:            return C_LW;
      6'b101011:            return C_SW;
      6'b000100, 6'b000101: return C_BR;
      6'b000010, 6'b000011: return C_J;
      default:              return C_ILL;
    endcase
  endfunction

  function automatic obs_t row(logic [3:0] st);
    obs_t r;
    r = '0;
    r.st = st;
    r.ill = m_ill;
    r.berr = m_berr;
    return r;
  endfunction

  function automatic obs_t fetch_row();
    obs_t r;
    r = row(T_FETCH);
    r.mrd = 1'b1; r.srcb = 2'b01; r.aluop = 4'b0001;
    return r;
  endfunction

  function automatic obs_t memaddr_row();
    obs_t r;
    r = row(T_MEM_ADDR);
    r.srca = 1'b1; r.srcb = 2'b10; r.aluop = 4'b0001;
    return r;
  endfunction

  function automatic obs_t memrd_row();
    obs_t r;
    r = row(T_MEM_RD);
    r.mrd = 1'b1; r.iord = 1'b1;
    return r;
  endfunction

  // ---------------- stimulus: one cycle per call, expectation queued ----------------
  task automatic step(obs_t e, logic rn, logic r, logic mr, logic [5:0] op, logic [5:0] fn);
    @(negedge clk);
    rst_n = rn;
    bus.run = r;
    bus.mem_ready = mr;
    bus.Opcode = op;
    bus.func = fn;
    sb.push_back(e);
  endtask

  task automatic go(obs_t e, logic mr);
    step(e, 1'b1, 1'($urandom), mr, 6'($urandom), 6'($urandom));
  endtask

  task automatic wait_phase(obs_t base, int unsigned lat, bit is_fetch, output bit timed_out);
    obs_t e;
    timed_out = 1'b0;
    for (int unsigned i = 0; i < lat; i++) begin
      go(base, 1'b0);
      if (i + 1 == TO) begin
        timed_out = 1'b1;
        m_berr = 1'b1;
        return;
      end
    end
    e = base;
    if (is_fetch) begin
      e.irw = 1'b1;
      e.pcw = 1'b1;
    end
    go(e, 1'b1);
  endtask

  task automatic run_instr(logic [5:0] op, logic [5:0] fn, int unsigned lat_f,
                           int unsigned lat_m, output bit trapped);
    obs_t e;
    bit to;
    logic [4:0] v;
    trapped = 1'b0;
    wait_phase(fetch_row(), lat_f, 1'b1, to);
    if (to) begin
      trapped = 1'b1;
      return;
    end
    e = row(T_DECODE);
    e.srcb = 2'b11; e.aluop = 4'b0001;
    step(e, 1'b1, 1'($urandom), 1'($urandom), op, fn);
    case (cls(op, fn))
      C_R: begin
        v = r_alu(fn);
        e = row(T_EXEC_R); e.srca = 1'b1; e.aluop = v[3:0];
        go(e, 1'($urandom));
        e = row(T_WB_R); e.rdst = 1'b1; e.rw = 1'b1;
        go(e, 1'($urandom));
      end
      C_JR: begin
        e = row(T_JR); e.pcw = 1'b1; e.pcsrc = 2'b11;
        go(e, 1'($urandom));
      end
      C_I: begin
        v = i_alu(op);
        e = row(T_EXEC_I); e.srca = 1'b1; e.srcb = 2'b10; e.aluop = v[3:0];
        go(e, 1'($urandom));
        e = row(T_WB_I); e.rw = 1'b1;
        go(e, 1'($urandom));
      end
      C_LW: begin
        go(memaddr_row(), 1'($urandom));
        wait_phase(memrd_row(), lat_m, 1'b0, to);
        if (to) begin
          trapped = 1'b1;
          return;
        end
        e = row(T_WB_MEM); e.rw = 1'b1; e.m2r = 1'b1;
        go(e, 1'($urandom));
      end
      C_SW: begin
        go(memaddr_row(), 1'($urandom));
        e = row(T_MEM_WR); e.mwr = 1'b1; e.iord = 1'b1;
        wait_phase(e, lat_m, 1'b0, to);
        if (to) trapped = 1'b1;
      end
      C_BR: begin
        e = row(T_BRANCH); e.srca = 1'b1; e.aluop = 4'b1010; e.pcwc = 1'b1;
        e.pcsrc = 2'b01; e.bneq = (op == 6'b000101);
        go(e, 1'($urandom));
      end
      C_J: begin
        e = row(T_JUMP); e.pcw = 1'b1; e.pcsrc = 2'b10;
        e.jal = (op == 6'b000011); e.rw = (op == 6'b000011);
        go(e, 1'($urandom));
      end
      default: begin
        m_ill = 1'b1;
        trapped = 1'b1;
      end
    endcase
  endtask

  // TRAP must hold with sticky flags until reset; then restart from IDLE.
  task automatic recover();
    repeat (3) go(row(T_TRAP), 1'($urandom));
    step(row(T_TRAP), 1'b0, 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom));
    m_ill = 1'b0;
    m_berr = 1'b0;
    step(row(T_IDLE), 1'b1, 1'b0, 1'($urandom), 6'($urandom), 6'($urandom));
    step(row(T_IDLE), 1'b1, 1'b1, 1'($urandom), 6'($urandom), 6'($urandom));
  endtask

  task automatic instr(logic [5:0] op, logic [5:0] fn, int unsigned lf, int unsigned lm);
    bit t;
    run_instr(op, fn, lf, lm, t);
    if (t) recover();
  endtask

  function automatic int unsigned pick_lat();
    int unsigned r;
    r = $urandom_range(0, 39);
    if (r == 0) return TO;
    if (r == 1) return TO - 1;
    return $urandom_range(0, 3);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    obs_t a, x;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        a.st = bus.state;       a.pcw = bus.PCWrite;   a.pcwc = bus.PCWriteCond;
        a.iord = bus.IorD;      a.mrd = bus.MemRead;   a.mwr = bus.MemWrite;
        a.irw = bus.IRWrite;    a.rdst = bus.RegDst;   a.rw = bus.RegWrite;
        a.m2r = bus.MemtoReg;   a.srca = bus.ALUSrcA;  a.srcb = bus.ALUSrcB;
        a.pcsrc = bus.PCSource; a.aluop = bus.ALUOp;   a.jal = bus.Jal;
        a.bneq = bus.Bneq;      a.ill = bus.illegal;   a.berr = bus.bus_err;
        n_vec++;
        if (a !== x) begin
          n_bad++;
          $display("FAIL cycle_vec%0d: got state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                   n_vec, a.st, a[22:0], x.st, x[22:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors so far", n_vec);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  logic [5:0] ops [17] = '{6'b000000, 6'b000000, 6'b000000, 6'b000010, 6'b000011,
                          6'b000100, 6'b000101, 6'b001000, 6'b001001, 6'b001010,
                          6'b001011, 6'b001100, 6'b001101, 6'b001111, 6'b100011,
                          6'b101011, 6'b110000};
  logic [5:0] fns [13] = '{6'b000000, 6'b000010, 6'b000011, 6'b001000, 6'b100000,
                          6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                          6'b100111, 6'b101010, 6'b101011};

  initial begin
    logic [5:0] op, fn;
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    bus.Opcode = '0;
    bus.func = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // IDLE ignores everything until run
    step(row(T_IDLE), 1'b1, 1'b0, 1'b1, 6'($urandom), 6'($urandom));
    step(row(T_IDLE), 1'b1, 1'b1, 1'b0, 6'($urandom), 6'($urandom));

    // lw interrupted by a one-cycle reset in MEM_RD
    begin
      bit to;
      obs_t e;
      wait_phase(fetch_row(), 0, 1'b1, to);
      e = row(T_DECODE); e.srcb = 2'b11; e.aluop = 4'b0001;
      step(e, 1'b1, 1'b0, 1'b0, 6'b100011, 6'($urandom));
      go(memaddr_row(), 1'b0);
      go(memrd_row(), 1'b0);
      go(memrd_row(), 1'b0);
      step(memrd_row(), 1'b0, 1'b1, 1'b0, 6'($urandom), 6'($urandom));
      step(row(T_IDLE), 1'b1, 1'b1, 1'b0, 6'($urandom), 6'($urandom));
    end

    // directed
    instr(6'b000000, 6'b100000, 0, 0);     // add
    instr(6'b100011, 6'($urandom), 0, 3);  // lw, 3 wait cycles
    instr(6'b000101, 6'($urandom), 1, 0);  // bne
    instr(6'b000011, 6'($urandom), 0, 0);  // jal
    instr(6'b000000, 6'b001000, 2, 0);     // jr
    instr(6'b101011, 6'($urandom), 0, 2);  // sw
    instr(6'b000000, 6'b100000, TO - 1, 0);  // ready on last allowed cycle
    instr(6'b000000, 6'b100000, TO, 0);      // fetch timeout
    instr(6'b100011, 6'($urandom), 0, TO);   // MEM_RD timeout
    instr(6'b101011, 6'($urandom), 0, TO - 1);
    instr(6'b111111, 6'($urandom), 0, 0);    // undefined opcode
    instr(6'b000000, 6'b111111, 0, 0);       // undefined func

    // random
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 16)];
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
      else fn = fns[$urandom_range(0, 12)];
      instr(op, fn, pick_lat(), pick_lat());
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
